ascon128_decrypt_1block: RTL and testbench

- Ascon-128 authenticated decryption core for one 64-bit associated-data block and one 64-bit ciphertext block.
- Inverse counterpart of the encryption datapath: takes key, nonce, AD, ciphertext and received tag.
- Recomputes the tag and releases plaintext only when the tag verifies.
- Sits behind the same registered-I/O top wrapper style as the encryptor; iterative, UNROLL permutation rounds per cycle.

---
 rtl/ascon_pkg.sv | 43 ++++
 rtl/ascon_round.sv | 48 ++++
 rtl/ascon128_decrypt_1block.sv | 148 ++++++++++++++
 tb/tb_ascon128_decrypt_1block.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared constants, types and helpers for the Ascon-128 decryption core.
package ascon_pkg;

    localparam logic [63:0] IV_128       = 64'h80400c0600000000;
    localparam logic [63:0] PAD          = 64'h8000000000000000;
    localparam logic [3:0]  ROUNDS_LONG  = 4'd12;
    localparam logic [3:0]  ROUNDS_SHORT = 4'd6;

    // Five 64-bit words; word i sits at bits [64*i +: 64] (x0 is the low word).
    typedef logic [4:0][63:0] ascon_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AD,
        S_ADPAD,
        S_CT,
        S_FINAL
    } phase_t;

    function automatic logic [7:0] round_const(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'hf0;
            4'd1:    return 8'he1;
            4'd2:    return 8'hd2;
            4'd3:    return 8'hc3;
            4'd4:    return 8'hb4;
            4'd5:    return 8'ha5;
            4'd6:    return 8'h96;
            4'd7:    return 8'h87;
            4'd8:    return 8'h78;
            4'd9:    return 8'h69;
            4'd10:   return 8'h5a;
            4'd11:   return 8'h4b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round: constant add, S-box layer, linear layer.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [319:0] s_in,
    input  logic [3:0]   rnd,
    output logic [319:0] s_out
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;
    logic [63:0] d0, d1, d2, d3, d4;

    // constant addition lands on x2
    assign a0 = s_in[63:0];
    assign a1 = s_in[127:64];
    assign a2 = s_in[191:128] ^ {56'h0, round_const(rnd)};
    assign a3 = s_in[255:192];
    assign a4 = s_in[319:256];

    // bit-sliced 5-bit S-box: input mix, chi, output mix
    assign b0 = a0 ^ a4;
    assign b1 = a1;
    assign b2 = a2 ^ a1;
    assign b3 = a3;
    assign b4 = a4 ^ a3;

    assign c0 = b0 ^ (~b1 & b2);
    assign c1 = b1 ^ (~b2 & b3);
    assign c2 = b2 ^ (~b3 & b4);
    assign c3 = b3 ^ (~b4 & b0);
    assign c4 = b4 ^ (~b0 & b1);

    assign d0 = c0 ^ c4;
    assign d1 = c1 ^ c0;
    assign d2 = ~c2;
    assign d3 = c3 ^ c2;
    assign d4 = c4;

    // per-word linear diffusion
    assign s_out[63:0]    = d0 ^ rotr(d0, 19) ^ rotr(d0, 28);
    assign s_out[127:64]  = d1 ^ rotr(d1, 61) ^ rotr(d1, 39);
    assign s_out[191:128] = d2 ^ rotr(d2, 1)  ^ rotr(d2, 6);
    assign s_out[255:192] = d3 ^ rotr(d3, 10) ^ rotr(d3, 17);
    assign s_out[319:256] = d4 ^ rotr(d4, 7)  ^ rotr(d4, 41);

endmodule

// File: rtl/ascon128_decrypt_1block.sv
// Ascon-128 decryption of one AD block and one ciphertext block, with tag check.
// Iterative: UNROLL rounds per cycle; plaintext released only on a matching tag.
module ascon128_decrypt_1block
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [127:0] SK,
    input  logic [127:0] N,
    input  logic [63:0]  A,
    input  logic [63:0]  C,
    input  logic [127:0] T_IN,
    output logic         busy,
    output logic         done,
    output logic [63:0]  P,
    output logic         tag_ok
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 6) begin : g_bad_unroll
        $error("ascon128_decrypt_1block: UNROLL must be 1, 2, 3 or 6");
    end

    localparam logic [3:0] STEP = 4'(UNROLL);

    phase_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   phase_len, rbase;
    logic         last;
    logic         done_d;
    ascon_state_t x_q, x_d, po;
    ascon_state_t chain [UNROLL+1];
    logic [127:0] key_q, tin_q;
    logic [63:0]  ad_q, ct_q, preg_q, preg_d, p_d;
    logic         tag_ok_d;

    assign busy     = (state_q != S_IDLE);
    assign chain[0] = x_q;
    assign po       = chain[UNROLL];

    // unrolled round chain; each stage takes the next round-constant index
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        ascon_round u_round (
            .s_in  (chain[k]),
            .rnd   (rbase + 4'(k)),
            .s_out (chain[k+1])
        );
    end

    assign tag_ok_d = ({po[3] ^ key_q[127:64], po[4] ^ key_q[63:0]} == tin_q);
    assign p_d      = tag_ok_d ? preg_q : 64'h0;

    // phase sequencing and round counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        phase_len = (state_q == S_INIT || state_q == S_FINAL) ? ROUNDS_LONG : ROUNDS_SHORT;
        rbase     = 4'd12 - phase_len + cnt_q;
        last      = (cnt_q + STEP == phase_len);
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_INIT;
                cnt_d   = 4'd0;
            end
        end else if (last) begin
            cnt_d = 4'd0;
            case (state_q)
                S_INIT:  state_d = S_AD;
                S_AD:    state_d = S_ADPAD;
                S_ADPAD: state_d = S_CT;
                S_CT:    state_d = S_FINAL;
                default: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            endcase
        end else begin
            cnt_d = cnt_q + STEP;
        end
    end

    // permutation state update with phase-boundary injections
    always_comb begin
        x_d    = x_q;
        preg_d = preg_q;
        if (state_q == S_IDLE) begin
            if (start) x_d = {N[63:0], N[127:64], SK[63:0], SK[127:64], IV_128};
        end else begin
            x_d = po;
            if (last) begin
                case (state_q)
                    S_INIT: begin
                        x_d[3] = po[3] ^ key_q[127:64];
                        x_d[4] = po[4] ^ key_q[63:0];
                        x_d[0] = po[0] ^ ad_q;
                    end
                    S_AD: x_d[0] = po[0] ^ PAD;
                    S_ADPAD: begin
                        x_d[4] = po[4] ^ 64'd1;
                        preg_d = po[0] ^ ct_q;
                        x_d[0] = ct_q;
                    end
                    S_CT: begin
                        x_d[0] = po[0] ^ PAD;
                        x_d[1] = po[1] ^ key_q[127:64];
                        x_d[2] = po[2] ^ key_q[63:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // control and result registers; reset aborts any job in flight
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            done    <= 1'b0;
            P       <= 64'h0;
            tag_ok  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done    <= done_d;
            if (done_d) begin
                P      <= p_d;
                tag_ok <= tag_ok_d;
            end
        end
    end

    // datapath registers; operands are captured only when a job is accepted
    always_ff @(posedge CLK) begin
        x_q    <= x_d;
        preg_q <= preg_d;
        if (state_q == S_IDLE && start) begin
            key_q <= SK;
            ad_q  <= A;
            ct_q  <= C;
            tin_q <= T_IN;
        end
    end

endmodule

// File: tb/tb_ascon128_decrypt_1block.sv
// Bench for ascon128_decrypt_1block: table of vectors built from a reference
// encryptor, plus busy-rejection, mid-job reset and back-to-back sequences.
module tb_ascon128_decrypt_1block;

    localparam int UNROLL    = 1;
    localparam int EXP_EDGES = 42 / UNROLL;
    localparam logic [63:0] PADW = 64'h8000000000000000;
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    logic         CLK = 1'b0;
    logic         RST, start;
    logic [127:0] SK, N, T_IN;
    logic [63:0]  A, C, P;
    logic         busy, done, tag_ok;

    always #5 CLK = ~CLK;

    ascon128_decrypt_1block #(.UNROLL(UNROLL)) dut (
        .CLK(CLK), .RST(RST), .start(start), .SK(SK), .N(N), .A(A), .C(C),
        .T_IN(T_IN), .busy(busy), .done(done), .P(P), .tag_ok(tag_ok));

    typedef logic [4:0][63:0] w5_t;
    typedef struct packed { logic [63:0] ct; logic [127:0] tag; } enc_t;
    typedef struct {
        logic [127:0] key, nonce;
        logic [63:0]  ad, ct;
        logic [127:0] tin;
        logic [63:0]  exp_p;
        logic         exp_ok;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v};
        return d[n +: 64];
    endfunction

    // reference permutation: table-lookup S-box applied column by column
    function automatic w5_t perm(input w5_t s_in, input int nr);
        w5_t s, t;
        logic [4:0] col, o;
        s = s_in;
        t = '0;
        for (int r = 12 - nr; r < 12; r++) begin
            s[2] = s[2] ^ 64'(240 - 15 * r);
            for (int j = 0; j < 64; j++) begin
                col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
                o = SBOX[col];
                t[0][j] = o[4]; t[1][j] = o[3]; t[2][j] = o[2]; t[3][j] = o[1]; t[4][j] = o[0];
            end
            s[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
            s[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
            s[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
            s[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
            s[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
        end
        return s;
    endfunction

    // reference Ascon-128 encryption of one AD block and one plaintext block
    function automatic enc_t encrypt(input logic [127:0] k, input logic [127:0] nonce,
                                     input logic [63:0] ad, input logic [63:0] pt);
        w5_t s;
        enc_t r;
        s[0] = 64'h80400c0600000000; s[1] = k[127:64]; s[2] = k[63:0];
        s[3] = nonce[127:64];        s[4] = nonce[63:0];
        s = perm(s, 12);
        s[3] ^= k[127:64]; s[4] ^= k[63:0];
        s[0] ^= ad;   s = perm(s, 6);
        s[0] ^= PADW; s = perm(s, 6);
        s[4] ^= 64'd1;
        s[0] ^= pt;   r.ct = s[0]; s = perm(s, 6);
        s[0] ^= PADW; s[1] ^= k[127:64]; s[2] ^= k[63:0];
        s = perm(s, 12);
        r.tag = {s[3] ^ k[127:64], s[4] ^ k[63:0]};
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        SK = v.key; N = v.nonce; A = v.ad; C = v.ct; T_IN = v.tin;
    endtask

    // call just after a negedge; returns #1 after the accepting edge
    task automatic pulse_start(input vec_t v);
        drive(v);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output bit gap);
        edges = -1;
        gap   = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge CLK); #1;
            if (done) begin
                edges = i;
                break;
            end
            if (!busy) gap = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int e;
        bit gap;
        @(negedge CLK);
        pulse_start(v);
        check($sformatf("v%0d_busy_after_start", id), 128'(busy), 128'(1));
        wait_done(e, gap);
        check($sformatf("v%0d_latency", id), 128'(e + 1), 128'(EXP_EDGES + 1));
        check($sformatf("v%0d_busy_gap", id), 128'(gap), 128'(0));
        check($sformatf("v%0d_busy_at_done", id), 128'(busy), 128'(0));
        check($sformatf("v%0d_P", id), 128'(P), 128'(v.exp_p));
        check($sformatf("v%0d_tag_ok", id), 128'(tag_ok), 128'(v.exp_ok));
        @(posedge CLK); #1;
        check($sformatf("v%0d_done_pulse", id), 128'(done), 128'(0));
    endtask

    initial begin
        vec_t v, w;
        enc_t e;
        int edges, ndone, first, p1, p2;
        bit gap;
        logic [63:0] cap_p;
        logic cap_ok;
        logic [127:0] kn;
        logic [63:0] adpt;

        // vector table
        kn   = 128'h000102030405060708090a0b0c0d0e0f;
        adpt = 64'h0001020304050607;
        e = encrypt(kn, kn, adpt, adpt);
        v.key = kn; v.nonce = kn; v.ad = adpt; v.ct = e.ct; v.tin = e.tag;
        v.exp_p = adpt; v.exp_ok = 1'b1;
        vecs.push_back(v);
        w = v; w.tin = v.tin ^ 128'd1;            w.exp_p = 64'h0; w.exp_ok = 1'b0; vecs.push_back(w);
        w = v; w.ct  = v.ct ^ PADW;               w.exp_p = 64'h0; w.exp_ok = 1'b0; vecs.push_back(w);
        w = v; w.ad  = v.ad ^ 64'd1;              w.exp_p = 64'h0; w.exp_ok = 1'b0; vecs.push_back(w);
        for (int i = 0; i < 24; i++) begin
            logic [63:0] pt;
            w.key   = {$urandom, $urandom, $urandom, $urandom};
            w.nonce = {$urandom, $urandom, $urandom, $urandom};
            w.ad    = {$urandom, $urandom};
            pt      = {$urandom, $urandom};
            e = encrypt(w.key, w.nonce, w.ad, pt);
            w.ct = e.ct; w.tin = e.tag; w.exp_p = pt; w.exp_ok = 1'b1;
            if (i % 2 == 1) begin
                if ($urandom_range(0, 1) == 0) w.tin = w.tin ^ (128'd1 << $urandom_range(0, 127));
                else                           w.ct  = w.ct  ^ (64'd1 << $urandom_range(0, 63));
                w.exp_p = 64'h0; w.exp_ok = 1'b0;
            end
            vecs.push_back(w);
        end

        // reset state
        RST = 1'b0; start = 1'b0;
        SK = '0; N = '0; A = '0; C = '0; T_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_P", 128'(P), 128'(0));
        check("reset_tag_ok", 128'(tag_ok), 128'(0));
        @(negedge CLK); RST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // busy rejection: restarts mid-job must be ignored
        p1 = (EXP_EDGES > 5) ? 5 : 2;
        p2 = (EXP_EDGES > 20) ? 20 : EXP_EDGES - 1;
        ndone = 0; first = -1; cap_p = '0; cap_ok = 1'b0;
        @(negedge CLK);
        pulse_start(vecs[0]);
        for (int i = 1; i <= EXP_EDGES + 30; i++) begin
            if (i == p1 || i == p2) begin
                drive(vecs[4 + i % 2]);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            if (done) begin
                ndone++;
                if (first < 0) begin first = i; cap_p = P; cap_ok = tag_ok; end
            end
        end
        start = 1'b0;
        check("busy_rej_done_count", 128'(ndone), 128'(1));
        check("busy_rej_latency", 128'(first + 1), 128'(EXP_EDGES + 1));
        check("busy_rej_P", 128'(cap_p), 128'(vecs[0].exp_p));
        check("busy_rej_tag_ok", 128'(cap_ok), 128'(1));

        // reset in the middle of a job
        @(negedge CLK);
        pulse_start(vecs[0]);
        repeat (9) @(posedge CLK);
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_P", 128'(P), 128'(0));
        check("midrst_tag_ok", 128'(tag_ok), 128'(0));
        RST = 1'b1;
        ndone = 0;
        for (int i = 0; i < EXP_EDGES + 20; i++) begin
            @(posedge CLK); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", 128'(ndone), 128'(0));
        run_vec(vecs[0], 100);

        // back-to-back: second start in the done cycle
        @(negedge CLK);
        pulse_start(vecs[0]);
        wait_done(edges, gap);
        check("b2b_first_latency", 128'(edges + 1), 128'(EXP_EDGES + 1));
        check("b2b_first_P", 128'(P), 128'(vecs[0].exp_p));
        drive(vecs[4]);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("b2b_accept_busy", 128'(busy), 128'(1));
        check("b2b_done_dropped", 128'(done), 128'(0));
        wait_done(edges, gap);
        check("b2b_second_latency", 128'(edges + 1), 128'(EXP_EDGES + 1));
        check("b2b_second_P", 128'(P), 128'(vecs[4].exp_p));
        check("b2b_second_tag_ok", 128'(tag_ok), 128'(vecs[4].exp_ok));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
